// File: rtl/dmem_ctrl.sv
// Data-memory controller: maps byte/half/word loads and stores onto a word-only SRAM.
// Define FRISCV_DMEM_MISALIGN_CHK_EN to drop misaligned/illegal requests with err_out; otherwise they are force-aligned.
module dmem_ctrl #(
  parameter int ARCH       = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_in,
  input  logic                  we_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [1:0]            size_in,
  input  logic                  unsigned_in,
  input  logic [ARCH-1:0]       wdata_in,
  output logic                  ready_out,
  output logic                  rvalid_out,
  output logic [ARCH-1:0]       rdata_out,
  output logic                  err_out,
  output logic [ADDR_WIDTH-1:0] sram_addr_a_out,
  output logic [ARCH-1:0]       sram_din_a_out,
  output logic                  sram_we_a_out,
  output logic [ADDR_WIDTH-1:0] sram_addr_b_out,
  output logic                  sram_en_b_out,
  input  logic [ARCH-1:0]       sram_dout_b_in
);
  // state     | meaning
  // IDLE      | accepting requests; word stores complete here
  // LD_WAIT   | SRAM read data arriving; extract, extend, register
  // RMW_MERGE | SRAM read data arriving; merge sub-word and write back
  localparam int LANES = ARCH / 8;
  localparam int OFF_W = $clog2(LANES);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LD_WAIT   = 2'd1;
  localparam logic [1:0] RMW_MERGE = 2'd2;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [OFF_W-1:0]      off_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [15:0]           wdata_q;

  logic [ADDR_WIDTH-1:0] addr_eff;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [1:0]            size_eff;
  logic                  bad;
  logic                  accept;
  logic                  is_word;
  logic                  needs_read;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [ARCH-1:0]       lane_data;
  logic [ARCH-1:0]       merged;

`ifdef FRISCV_DMEM_MISALIGN_CHK_EN
  always_comb begin
    size_eff = size_in;
    addr_eff = addr_in;
    bad      = (size_in == 2'b11) ||
               (size_in == 2'b01 && addr_in[0]) ||
               (size_in == 2'b10 && addr_in[1:0] != 2'b00);
  end
`else
  always_comb begin
    size_eff = (size_in == 2'b11) ? 2'b10 : size_in;
    addr_eff = addr_in;
    bad      = 1'b0;
    if (size_eff == 2'b01)
      addr_eff[0] = 1'b0;
    else if (size_eff == 2'b10)
      addr_eff[1:0] = 2'b00;
  end
`endif

  assign word_addr  = {addr_eff[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  assign accept     = req_in && (state == IDLE) && !bad;
  assign is_word    = (size_eff == 2'b10);
  assign needs_read = accept && !(we_in && is_word);

  assign ready_out       = (state == IDLE);
  assign sram_addr_a_out = (state == IDLE) ? word_addr : addr_q;
  assign sram_addr_b_out = (state == IDLE) ? word_addr : addr_q;
  assign sram_we_a_out   = (accept && we_in && is_word) || (state == RMW_MERGE);
  assign sram_din_a_out  = (state == RMW_MERGE) ? merged : wdata_in;
  assign sram_en_b_out   = needs_read;

  // Little-endian lanes: byte at 8*off, half at 16*off[1]
  assign byte_sel = sram_dout_b_in[8*int'(off_q) +: 8];
  assign half_sel = sram_dout_b_in[16*(int'(off_q)/2) +: 16];

  always_comb begin
    case (size_q)
      2'b00:   lane_data = {{(ARCH-8){~uns_q & byte_sel[7]}}, byte_sel};
      2'b01:   lane_data = {{(ARCH-16){~uns_q & half_sel[15]}}, half_sel};
      default: lane_data = sram_dout_b_in;
    endcase
  end

  always_comb begin
    merged = sram_dout_b_in;
    if (size_q == 2'b00)
      merged[8*int'(off_q) +: 8] = wdata_q[7:0];
    else
      merged[16*(int'(off_q)/2) +: 16] = wdata_q[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      off_q      <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      wdata_q    <= '0;
      rdata_out  <= '0;
      rvalid_out <= 1'b0;
    end else begin
      rvalid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (needs_read) begin
            addr_q  <= word_addr;
            off_q   <= addr_eff[OFF_W-1:0];
            size_q  <= size_eff;
            uns_q   <= unsigned_in;
            wdata_q <= wdata_in[15:0];
            state   <= we_in ? RMW_MERGE : LD_WAIT;
          end
        end
        LD_WAIT: begin
          rdata_out  <= lane_data;
          rvalid_out <= 1'b1;
          state      <= IDLE;
        end
        RMW_MERGE: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

`ifdef FRISCV_DMEM_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_out <= 1'b0;
    else
      err_out <= req_in && (state == IDLE) && bad;
  end
`else
  assign err_out = 1'b0;
`endif

endmodule
